cv32e40p_fault_manager: RTL and testbench

CV32E40P_FAULT_MANAGER -- requirements
Module: cv32e40p_fault_manager

---
 rtl/cv32e40p_pkg.sv | 19 +
 rtl/cv32e40p_fault_leak_timer.sv | 28 ++
 rtl/cv32e40p_fault_manager.sv | 108 ++++++++++
 tb/tb_cv32e40p_fault_manager.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types and helpers for the cv32e40p fault-tolerance slice.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECOVER = 2'd1,
    LOCK    = 2'd2
  } fault_mgr_state_e;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cv32e40p_fault_leak_timer.sv
// Cycle timer that pulses tick once every LEAK_PERIOD enabled cycles.
module cv32e40p_fault_leak_timer #(
  parameter int unsigned LEAK_PERIOD = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int unsigned TW = (LEAK_PERIOD > 2) ? $clog2(LEAK_PERIOD) : 1;
  localparam logic [TW-1:0] LAST = TW'(LEAK_PERIOD - 1);

  logic [TW-1:0] cnt_q;

  assign tick = en && !restart && (cnt_q == LAST);

  // restart wins over counting; the count holds while disabled
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + TW'(1);
    end
  end

endmodule

// File: rtl/cv32e40p_fault_manager.sv
// Counts voter mismatches, requests recovery and locks into an alarm on repeated faults.
module cv32e40p_fault_manager
  import cv32e40p_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 3,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned THRESHOLD   = 4,
  parameter int unsigned LEAK_PERIOD = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC-1:0]       fault_i,
  input  logic                     clear_i,
  input  logic                     recover_ack_i,
  output logic                     recover_req_o,
  output logic                     alarm_o,
  output logic [NUM_SRC-1:0]       fault_sticky_o,
  output logic [CNT_W-1:0]         fault_cnt_o,
  output logic [NUM_SRC*CNT_W-1:0] src_cnt_o
);

  localparam int unsigned SUM_W = CNT_W + 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fault_mgr_state_e state_q, state_next;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_add;
  logic             any_fault, over_th;
  logic             req_d, alarm_d;
  logic             leak_en, leak_restart, leak_tick;

  // saturating total after this cycle's faults
  always_comb begin
    any_fault = |fault_i;
    cnt_sum   = SUM_W'(fault_cnt_o) + SUM_W'(popcount(32'(fault_i)));
    cnt_add   = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    over_th   = SUM_W'(cnt_add) >= SUM_W'(THRESHOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    unique case (state_q)
      IDLE: begin
        if (any_fault) state_next = over_th ? LOCK : RECOVER;
      end
      RECOVER: begin
        if (any_fault && over_th) state_next = LOCK;
        else if (recover_ack_i)   state_next = IDLE;
      end
      LOCK:    state_next = LOCK;
      default: state_next = IDLE;
    endcase
    if (clear_i) state_next = IDLE;
  end

  always_comb begin
    req_d   = 1'b0;
    alarm_d = 1'b0;
    if (state_next == RECOVER) req_d = 1'b1;
    if (state_next == LOCK)    alarm_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      recover_req_o <= 1'b0;
      alarm_o       <= 1'b0;
    end else begin
      recover_req_o <= req_d;
      alarm_o       <= alarm_d;
    end
  end

  // only an idle, fault-free, nonzero total leaks
  assign leak_en      = (state_q == IDLE) && (fault_cnt_o != '0) && !any_fault;
  assign leak_restart = any_fault || clear_i || (state_next != state_q);

  cv32e40p_fault_leak_timer #(
    .LEAK_PERIOD(LEAK_PERIOD)
  ) u_leak_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (leak_en),
    .restart(leak_restart),
    .tick   (leak_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      fault_sticky_o <= '0;
      fault_cnt_o    <= '0;
      src_cnt_o      <= '0;
    end else begin
      fault_sticky_o <= fault_sticky_o | fault_i;
      fault_cnt_o    <= leak_tick ? fault_cnt_o - CNT_W'(1) : cnt_add;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (fault_i[i] && (src_cnt_o[i*CNT_W +: CNT_W] != CNT_MAX)) begin
          src_cnt_o[i*CNT_W +: CNT_W] <= src_cnt_o[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_fault_manager.sv
// Randomized and directed check of two fault manager configurations against a reference model.
module tb_cv32e40p_fault_manager;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] fault;
  logic       clr, ack;

  logic       req0, alarm0, req1, alarm1;
  logic [2:0] sticky0, sticky1;
  logic [7:0] fcnt0;
  logic [1:0] fcnt1;
  logic [23:0] src0;
  logic [5:0]  src1;

  always #5 clk = ~clk;

  cv32e40p_fault_manager #(.NUM_SRC(3), .CNT_W(8), .THRESHOLD(4), .LEAK_PERIOD(256)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .fault_i(fault), .clear_i(clr), .recover_ack_i(ack),
    .recover_req_o(req0), .alarm_o(alarm0), .fault_sticky_o(sticky0),
    .fault_cnt_o(fcnt0), .src_cnt_o(src0)
  );

  cv32e40p_fault_manager #(.NUM_SRC(3), .CNT_W(2), .THRESHOLD(3), .LEAK_PERIOD(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .fault_i(fault), .clear_i(clr), .recover_ack_i(ack),
    .recover_req_o(req1), .alarm_o(alarm1), .fault_sticky_o(sticky1),
    .fault_cnt_o(fcnt1), .src_cnt_o(src1)
  );

  typedef enum {M_QUIET, M_REPAIR, M_DEAD} mode_e;

  int unsigned cw[2] = '{8, 2};
  int unsigned th[2] = '{4, 3};
  int unsigned lp[2] = '{256, 4};

  mode_e       mode[2];
  int unsigned m_fcnt[2], m_leak[2], m_sticky[2];
  int unsigned m_src[2][3];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int m, input logic [2:0] f, input logic c, input logic a, input logic r);
    int unsigned maxv, pc, newcnt;
    mode_e prev;
    maxv = (1 << cw[m]) - 1;
    if (!r || c) begin
      mode[m] = M_QUIET; m_fcnt[m] = 0; m_leak[m] = 0; m_sticky[m] = 0;
      for (int i = 0; i < 3; i++) m_src[m][i] = 0;
      return;
    end
    pc = 0;
    for (int i = 0; i < 3; i++) begin
      if (f[i]) begin
        pc++;
        if (m_src[m][i] < maxv) m_src[m][i]++;
      end
    end
    m_sticky[m] = m_sticky[m] | int'(f);
    newcnt = (m_fcnt[m] + pc > maxv) ? maxv : m_fcnt[m] + pc;
    prev = mode[m];
    case (mode[m])
      M_QUIET:  if (pc > 0) mode[m] = (newcnt >= th[m]) ? M_DEAD : M_REPAIR;
      M_REPAIR: if (pc > 0 && newcnt >= th[m]) mode[m] = M_DEAD;
                else if (a) mode[m] = M_QUIET;
      default: ;
    endcase
    if (pc > 0 || mode[m] != prev) m_leak[m] = 0;
    else if (prev == M_QUIET && m_fcnt[m] > 0) begin
      if (m_leak[m] == lp[m] - 1) begin
        newcnt = m_fcnt[m] - 1;
        m_leak[m] = 0;
      end else m_leak[m]++;
    end
    m_fcnt[m] = newcnt;
  endtask

  task automatic compare_all();
    int unsigned exp_src;
    for (int m = 0; m < 2; m++) begin
      exp_src = 0;
      for (int i = 0; i < 3; i++) exp_src = exp_src | (m_src[m][i] << (i * cw[m]));
      check_val($sformatf("req%0d", m),    (m == 0) ? 32'(req0) : 32'(req1),       32'(mode[m] == M_REPAIR));
      check_val($sformatf("alarm%0d", m),  (m == 0) ? 32'(alarm0) : 32'(alarm1),   32'(mode[m] == M_DEAD));
      check_val($sformatf("sticky%0d", m), (m == 0) ? 32'(sticky0) : 32'(sticky1), m_sticky[m]);
      check_val($sformatf("fcnt%0d", m),   (m == 0) ? 32'(fcnt0) : 32'(fcnt1),     m_fcnt[m]);
      check_val($sformatf("src%0d", m),    (m == 0) ? 32'(src0) : 32'(src1),       exp_src);
    end
  endtask

  task automatic step(input logic [2:0] f, input logic c, input logic a, input logic r);
    fault = f; clr = c; ack = a; rst_n = r;
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) model_step(m, f, c, a, r);
    compare_all();
  endtask

  initial begin
    logic [2:0] f;
    int unsigned rate;
    fault = '0; clr = 1'b0; ack = 1'b0; rst_n = 1'b0;
    step(3'b000, 0, 0, 0);
    step(3'b000, 0, 0, 0);
    check_val("reset_req", 32'(req0), 0);
    check_val("reset_cnt", 32'(fcnt0), 0);

    // single fault, ack three cycles later
    step(3'b001, 0, 0, 1);
    check_val("single_req", 32'(req0), 1);
    check_val("single_cnt", 32'(fcnt0), 1);
    check_val("single_sticky", 32'(sticky0), 1);
    step(3'b000, 0, 0, 1);
    step(3'b000, 0, 0, 1);
    step(3'b000, 0, 1, 1);
    check_val("ack_req", 32'(req0), 0);

    // fault together with ack below threshold, then leak 2->1->0
    step(3'b000, 1, 0, 1);
    step(3'b001, 0, 0, 1);
    step(3'b001, 0, 1, 1);
    check_val("fault_ack_req", 32'(req0), 0);
    check_val("fault_ack_cnt", 32'(fcnt0), 2);
    for (int k = 0; k < 255; k++) step(3'b000, 0, 0, 1);
    check_val("leak_pre", 32'(fcnt0), 2);
    step(3'b000, 0, 0, 1);
    check_val("leak_1", 32'(fcnt0), 1);
    for (int k = 0; k < 256; k++) step(3'b000, 0, 0, 1);
    check_val("leak_0", 32'(fcnt0), 0);
    check_val("leak_src", 32'(src0), 2);

    // threshold reached from RECOVER
    step(3'b000, 1, 0, 1);
    step(3'b111, 0, 0, 1);
    check_val("th_cnt3", 32'(fcnt0), 3);
    check_val("th_req", 32'(req0), 1);
    step(3'b001, 0, 1, 1);
    check_val("th_cnt4", 32'(fcnt0), 4);
    check_val("th_alarm", 32'(alarm0), 1);
    check_val("th_req0", 32'(req0), 0);

    // clear beats a same-cycle fault in LOCK
    step(3'b010, 1, 0, 1);
    check_val("clr_alarm", 32'(alarm0), 0);
    check_val("clr_cnt", 32'(fcnt0), 0);
    check_val("clr_sticky", 32'(sticky0), 0);
    check_val("clr_src", 32'(src0), 0);

    // saturation in the narrow instance
    for (int k = 0; k < 5; k++) step(3'b100, 0, 0, 1);
    check_val("sat_src2", 32'(src1[5:4]), 3);
    check_val("sat_cnt", 32'(fcnt1), 3);

    // reset in RECOVER, later ack ignored
    step(3'b000, 1, 0, 1);
    step(3'b001, 0, 0, 1);
    step(3'b000, 0, 0, 0);
    check_val("rst_req", 32'(req0), 0);
    check_val("rst_cnt", 32'(fcnt0), 0);
    step(3'b000, 0, 1, 1);
    check_val("rst_ack_req", 32'(req0), 0);

    // random traffic with quiet windows so leaking is exercised
    rate = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 64 == 0) rate = $urandom_range(0, 2);
      f = '0;
      for (int i = 0; i < 3; i++)
        if (rate != 0 && $urandom_range(0, 15) < rate) f[i] = 1'b1;
      step(f, $urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 299) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
